// File: rtl/cordic_result_collector.sv
// Pairs consecutive CORDIC result words into (cos, sin), buffers DEPTH pairs and back-pressures the core.
// Define CORDIC_SAT_CHECK_EN to clamp stored words to +/-1.0 and report clamps on Ovf.
module cordic_result_collector #(
  parameter int W     = 13,
  parameter int DEPTH = 8
) (
  input  logic                     CLK1,
  input  logic                     RST,
  input  logic                     Flush,
  input  logic [W-1:0]             Data_Out,
  input  logic                     Data_Ready,
  output logic                     IN_N_OUT,
  output logic [W-1:0]             Res_Cos,
  output logic [W-1:0]             Res_Sin,
  output logic                     Res_Valid,
  input  logic                     Res_Ready,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Drop,
  output logic                     Ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0] S_COS = 1'b0;
  localparam logic [0:0] S_SIN = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [W-1:0]   cos_hold_q, cos_hold_d;
  logic [2*W-1:0] mem_q [DEPTH];
  logic [2*W-1:0] mem_d [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [W-1:0]   res_cos_q, res_cos_d;
  logic [W-1:0]   res_sin_q, res_sin_d;
  logic           res_valid_q, res_valid_d;
  logic           drop_q, drop_d;

  logic           in_n_out;
  logic           accept;
  logic           push;
  logic           pop;
  logic [W-1:0]   word_in;

  assign in_n_out = (count_q < CW'(DEPTH));
  assign accept   = Data_Ready & in_n_out;

`ifdef CORDIC_SAT_CHECK_EN
  localparam logic [W-1:0] POS_ONE = W'(1024);
  localparam logic [W-1:0] NEG_ONE = W'(-1024);

  logic clamp_hit;
  logic ovf_q, ovf_d;

  always_comb begin
    word_in   = Data_Out;
    clamp_hit = 1'b0;
    if ($signed(Data_Out) > $signed(POS_ONE)) begin
      word_in   = POS_ONE;
      clamp_hit = 1'b1;
    end else if ($signed(Data_Out) < $signed(NEG_ONE)) begin
      word_in   = NEG_ONE;
      clamp_hit = 1'b1;
    end
    ovf_d = ovf_q | (accept & clamp_hit & ~Flush);
  end

  always_ff @(posedge CLK1) begin
    if (RST) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign Ovf = ovf_q;
`else
  assign word_in = Data_Out;
  assign Ovf     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cos_hold_d  = cos_hold_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    res_cos_d   = res_cos_q;
    res_sin_d   = res_sin_q;
    res_valid_d = res_valid_q;
    drop_d      = drop_q;
    push        = 1'b0;
    pop         = 1'b0;

    if (Flush) begin
      state_d     = S_COS;
      cos_hold_d  = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      res_valid_d = 1'b0;
    end else begin
      drop_d = drop_q | (Data_Ready & ~in_n_out);
      pop    = res_valid_q & Res_Ready;
      push   = accept & (state_q == S_SIN);

      if (accept) begin
        if (state_q == S_COS) begin
          cos_hold_d = word_in;
          state_d    = S_SIN;
        end else begin
          state_d    = S_COS;
        end
      end

      if (push) begin
        mem_d[wr_ptr_q] = {cos_hold_q, word_in};
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

      count_d     = count_q + CW'(push) - CW'(pop);
      res_valid_d = (count_d != '0);

      // Head register looks ahead: a push into a FIFO that is empty after this
      // cycle's pop bypasses the memory, otherwise the head is read from mem_q.
      if (count_d != '0) begin
        if (push && (count_q == CW'(pop))) begin
          res_cos_d = cos_hold_q;
          res_sin_d = word_in;
        end else begin
          {res_cos_d, res_sin_d} = mem_q[rd_ptr_d];
        end
      end
    end
  end

  always_ff @(posedge CLK1) begin
    if (RST) begin
      state_q     <= S_COS;
      cos_hold_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      res_cos_q   <= '0;
      res_sin_q   <= '0;
      res_valid_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cos_hold_q  <= cos_hold_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      res_cos_q   <= res_cos_d;
      res_sin_q   <= res_sin_d;
      res_valid_q <= res_valid_d;
      drop_q      <= drop_d;
    end
  end

  always_ff @(posedge CLK1) begin
    mem_q <= mem_d;
  end

  assign IN_N_OUT  = in_n_out;
  assign Res_Cos   = res_cos_q;
  assign Res_Sin   = res_sin_q;
  assign Res_Valid = res_valid_q;
  assign Count     = count_q;
  assign Drop      = drop_q;

endmodule

// File: tb/tb_cordic_result_collector.sv
// Self-checking bench for cordic_result_collector against a queue-based pairing model.
// Honors CORDIC_SAT_CHECK_EN the same way as the design.
module tb_cordic_result_collector;

  localparam int W     = 13;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          CLK1 = 1'b0;
  logic          RST;
  logic          Flush;
  logic [W-1:0]  Data_Out;
  logic          Data_Ready;
  logic          IN_N_OUT;
  logic [W-1:0]  Res_Cos;
  logic [W-1:0]  Res_Sin;
  logic          Res_Valid;
  logic          Res_Ready;
  logic [CW-1:0] Count;
  logic          Drop;
  logic          Ovf;

  int checks = 0;
  int errors = 0;

  logic [2*W-1:0] mq[$];
  logic           pend;
  logic [W-1:0]   mcos;
  logic           mdrop;
  logic           movf;

  cordic_result_collector #(.W(W), .DEPTH(DEPTH)) dut (
    .CLK1(CLK1), .RST(RST), .Flush(Flush), .Data_Out(Data_Out), .Data_Ready(Data_Ready),
    .IN_N_OUT(IN_N_OUT), .Res_Cos(Res_Cos), .Res_Sin(Res_Sin), .Res_Valid(Res_Valid),
    .Res_Ready(Res_Ready), .Count(Count), .Drop(Drop), .Ovf(Ovf)
  );

  always #5 CLK1 = ~CLK1;

  // Returns {clamped_flag, stored_word}.
  function automatic logic [W:0] sat(input logic [W-1:0] w);
`ifdef CORDIC_SAT_CHECK_EN
    int v;
    v = int'($signed(w));
    if (v > 1024)  return {1'b1, 13'h0400};
    if (v < -1024) return {1'b1, 13'h1C00};
`endif
    return {1'b0, w};
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, sample #1 later.
  task automatic step(input logic s, input logic [W-1:0] d, input logic rdy, input logic fl);
    logic in_ok, do_pop;
    logic [W:0] sv;
    Data_Ready = s; Data_Out = d; Res_Ready = rdy; Flush = fl;
    in_ok  = (mq.size() < DEPTH);
    do_pop = (mq.size() != 0) && rdy;
    @(posedge CLK1);
    if (fl) begin
      mq.delete();
      pend = 1'b0;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (s && !in_ok) mdrop = 1'b1;
      else if (s) begin
        sv = sat(d);
        if (sv[W]) movf = 1'b1;
        if (pend) begin
          mq.push_back({mcos, sv[W-1:0]});
          pend = 1'b0;
        end else begin
          mcos = sv[W-1:0];
          pend = 1'b1;
        end
      end
    end
    #1;
    Data_Ready = 1'b0; Res_Ready = 1'b0; Flush = 1'b0;
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    Data_Ready = 1'b0; Res_Ready = 1'b0; Flush = 1'b0; Data_Out = '0;
    @(posedge CLK1); @(posedge CLK1); #1;
    RST = 1'b0;
    mq.delete(); pend = 1'b0; mcos = '0; mdrop = 1'b0; movf = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (Res_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", Res_Valid); end
    checks++; if (Count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", Count); end
    checks++; if (IN_N_OUT !== 1'b1) begin errors++; $display("FAIL reset_in_n_out: got %b expected 1", IN_N_OUT); end
    checks++; if ({Res_Cos, Res_Sin} !== '0) begin errors++; $display("FAIL reset_data: got %h/%h expected 0/0", Res_Cos, Res_Sin); end
    checks++; if ({Drop, Ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b%b expected 00", Drop, Ovf); end
  endtask

  task automatic test_single_pair();
    step(1'b1, 13'h0400, 1'b0, 1'b0);
    checks++; if (Res_Valid !== 1'b0) begin errors++; $display("FAIL single_cos_only: valid %b expected 0", Res_Valid); end
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 13'h0000, 1'b0, 1'b0);
    checks++; if (Res_Valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", Res_Valid); end
    checks++; if (Res_Cos !== 13'h0400 || Res_Sin !== 13'h0000) begin errors++; $display("FAIL single_data: got %h/%h expected 0400/0000", Res_Cos, Res_Sin); end
    checks++; if (Count !== CW'(1)) begin errors++; $display("FAIL single_count: got %0d expected 1", Count); end
    step(1'b0, '0, 1'b1, 1'b0);
    checks++; if (Count !== '0 || Res_Valid !== 1'b0) begin errors++; $display("FAIL single_pop: count %0d valid %b expected 0 0", Count, Res_Valid); end
  endtask

  task automatic test_fill_backpressure();
    for (int i = 0; i < 2*DEPTH; i++) step(1'b1, W'($urandom_range(0, 8191)), 1'b0, 1'b0);
    checks++; if (Count !== CW'(DEPTH) || IN_N_OUT !== 1'b0) begin errors++; $display("FAIL fill_full: count %0d in %b expected %0d 0", Count, IN_N_OUT, DEPTH); end
    checks++; if (Drop !== 1'b0) begin errors++; $display("FAIL fill_no_drop: got %b expected 0", Drop); end
    step(1'b1, 13'h0123, 1'b0, 1'b0);
    checks++; if (Drop !== 1'b1 || Count !== CW'(DEPTH)) begin errors++; $display("FAIL fill_drop: drop %b count %0d expected 1 %0d", Drop, Count, DEPTH); end
    checks++; if (Res_Cos !== mq[0][2*W-1:W] || Res_Sin !== mq[0][W-1:0]) begin errors++; $display("FAIL fill_head: got %h/%h expected %h", Res_Cos, Res_Sin, mq[0]); end
    step(1'b0, '0, 1'b1, 1'b0);
    checks++; if (IN_N_OUT !== 1'b1 || Count !== CW'(DEPTH-1)) begin errors++; $display("FAIL fill_release: in %b count %0d expected 1 %0d", IN_N_OUT, Count, DEPTH-1); end
    for (int i = 0; i < DEPTH + 2 && mq.size() != 0; i++) begin
      checks++;
      if (Res_Valid !== 1'b1 || {Res_Cos, Res_Sin} !== mq[0]) begin
        errors++; $display("FAIL fill_order: got %b %h/%h expected 1 %h", Res_Valid, Res_Cos, Res_Sin, mq[0]);
      end
      step(1'b0, '0, 1'b1, 1'b0);
    end
    checks++; if (Res_Valid !== 1'b0 || Count !== '0) begin errors++; $display("FAIL fill_drained: valid %b count %0d expected 0 0", Res_Valid, Count); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] c, s;
    for (int i = 0; i < 2*(DEPTH-1); i++) step(1'b1, W'($urandom_range(0, 2047)), 1'b0, 1'b0);
    c = 13'h0155; s = 13'h1EAB;
    step(1'b1, c, 1'b0, 1'b0);
    step(1'b1, s, 1'b1, 1'b0);
    checks++; if (Count !== CW'(DEPTH-1)) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", Count, DEPTH-1); end
    for (int i = 0; i < DEPTH + 2 && mq.size() != 0; i++) begin
      checks++;
      if ({Res_Cos, Res_Sin} !== mq[0]) begin
        errors++; $display("FAIL b2b_order: got %h/%h expected %h", Res_Cos, Res_Sin, mq[0]);
      end
      if (mq.size() == 1) begin
        checks++;
        if (Res_Cos !== c || Res_Sin !== s) begin errors++; $display("FAIL b2b_last: got %h/%h expected %h/%h", Res_Cos, Res_Sin, c, s); end
      end
      step(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_flush_rst();
    step(1'b1, 13'h0011, 1'b0, 1'b0);
    step(1'b1, 13'h0022, 1'b0, 1'b0);
    step(1'b1, 13'h0033, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    checks++; if (Count !== '0 || Res_Valid !== 1'b0 || IN_N_OUT !== 1'b1) begin errors++; $display("FAIL flush_clear: count %0d valid %b in %b expected 0 0 1", Count, Res_Valid, IN_N_OUT); end
    checks++; if (Drop !== 1'b1) begin errors++; $display("FAIL flush_keeps_drop: got %b expected 1", Drop); end
    step(1'b1, 13'h0044, 1'b0, 1'b0);
    step(1'b1, 13'h0055, 1'b0, 1'b0);
    checks++; if (Count !== CW'(1) || Res_Cos !== 13'h0044 || Res_Sin !== 13'h0055) begin errors++; $display("FAIL flush_fresh_pair: count %0d %h/%h expected 1 0044/0055", Count, Res_Cos, Res_Sin); end
    step(1'b1, 13'h0066, 1'b0, 1'b0);
    apply_reset();
    checks++; if (Res_Valid !== 1'b0 || Count !== '0 || IN_N_OUT !== 1'b1 || {Res_Cos, Res_Sin} !== '0) begin errors++; $display("FAIL rst_outputs: valid %b count %0d in %b data %h/%h expected reset", Res_Valid, Count, IN_N_OUT, Res_Cos, Res_Sin); end
    checks++; if (Drop !== 1'b0) begin errors++; $display("FAIL rst_drop: got %b expected 0", Drop); end
    step(1'b1, 13'h0077, 1'b0, 1'b0);
    step(1'b1, 13'h0088, 1'b0, 1'b0);
    checks++; if (Count !== CW'(1) || Res_Cos !== 13'h0077 || Res_Sin !== 13'h0088) begin errors++; $display("FAIL rst_fresh_pair: count %0d %h/%h expected 1 0077/0088", Count, Res_Cos, Res_Sin); end
  endtask

  task automatic test_saturation();
    logic [W-1:0] ec, es;
    logic         eo;
`ifdef CORDIC_SAT_CHECK_EN
    ec = 13'h0400; es = 13'h1C00; eo = 1'b1;
`else
    ec = 13'h0600; es = 13'h1A00; eo = 1'b0;
`endif
    apply_reset();
    step(1'b1, 13'h0600, 1'b0, 1'b0);
    step(1'b1, 13'h1A00, 1'b0, 1'b0);
    checks++; if (Res_Cos !== ec || Res_Sin !== es) begin errors++; $display("FAIL sat_data: got %h/%h expected %h/%h", Res_Cos, Res_Sin, ec, es); end
    checks++; if (Ovf !== eo) begin errors++; $display("FAIL sat_ovf: got %b expected %b", Ovf, eo); end
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic s, r, f;
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 9) < 6);
      r = ($urandom_range(0, 9) < 4);
      f = ($urandom_range(0, 49) == 0);
      step(s, W'($urandom_range(0, 8191)), r, f);
      checks++;
      if (Count !== CW'(mq.size()) || Res_Valid !== (mq.size() != 0) || IN_N_OUT !== (mq.size() < DEPTH)) begin
        errors++; $display("FAIL rand_state: cyc %0d count %0d valid %b in %b expected count %0d", i, Count, Res_Valid, IN_N_OUT, mq.size());
      end
      checks++;
      if (Drop !== mdrop || Ovf !== movf) begin
        errors++; $display("FAIL rand_flags: cyc %0d drop %b ovf %b expected %b %b", i, Drop, Ovf, mdrop, movf);
      end
      if (mq.size() != 0) begin
        checks++;
        if ({Res_Cos, Res_Sin} !== mq[0]) begin
          errors++; $display("FAIL rand_head: cyc %0d got %h/%h expected %h", i, Res_Cos, Res_Sin, mq[0]);
        end
      end
    end
  endtask

  initial begin
    RST = 1'b1; Flush = 1'b0; Data_Ready = 1'b0; Res_Ready = 1'b0; Data_Out = '0;
    pend = 1'b0; mcos = '0; mdrop = 1'b0; movf = 1'b0;
    test_reset();
    test_single_pair();
    test_fill_backpressure();
    test_back_to_back();
    test_flush_rst();
    test_saturation();
    apply_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
